microcode_loader: RTL and testbench

Writes a microprogram into the MIC-1 control store's write port from an 8-bit byte stream, so the control store can be loaded at runtime rather than only from its power-on image. It packs five bytes into each 36-bit microinstruction and writes the words to consecutive addresses starting at 0. It holds the datapath in halt while loading. It sits between a host byte source (UART receiver or debug bridge) and the control store's `wen`/`waddr`/`wdata` port.

---
 rtl/mic1_pkg.sv | 15 +
 rtl/mic1_word_packer.sv | 43 ++++
 rtl/microcode_loader.sv | 141 ++++++++++++++
 tb/tb_microcode_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_pkg.sv
// Shared MIC-1 control-store constants and the microcode loader state encoding.
package mic1_pkg;
    localparam int CS_ADDR_W         = 9;
    localparam int CS_DATA_W         = 36;
    localparam int CS_DEPTH          = 1 << CS_ADDR_W;
    localparam int CS_BYTES_PER_WORD = (CS_DATA_W + 7) / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } loader_state_t;
endpackage

// File: rtl/mic1_word_packer.sv
// Assembles a little-endian microinstruction from a byte stream, one register per byte lane.
module mic1_word_packer
    import mic1_pkg::*;
#(
    parameter int DATA_W = CS_DATA_W,
    parameter int BYTES  = CS_BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [7:0]        data,
    output logic [DATA_W-1:0] word,
    output logic              last
);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0] idx_q;

    assign last = (idx_q == IDX_W'(BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            idx_q <= '0;
        else if (load)
            idx_q <= last ? '0 : idx_q + IDX_W'(1);
    end

    // The top lane is only as wide as the bits left over; its surplus input bits are dropped.
    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        localparam int LW = (DATA_W - 8 * i >= 8) ? 8 : DATA_W - 8 * i;
        logic [LW-1:0] q;

        always_ff @(posedge clk) begin
            if (!rst_n || clr)
                q <= '0;
            else if (load && idx_q == IDX_W'(i))
                q <= data[LW-1:0];
        end

        assign word[8*i +: LW] = q;
    end
endmodule

// File: rtl/microcode_loader.sv
// Streams bytes into the MIC-1 control store write port, holding the CPU while loading.
// Optional trailing checksum byte enabled by `MICROCODE_LOADER_CHECKSUM_EN.
module microcode_loader
    import mic1_pkg::*;
#(
    parameter int ADDR_W         = CS_ADDR_W,
    parameter int DATA_W         = CS_DATA_W,
    parameter int BYTES_PER_WORD = (DATA_W + 7) / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              cs_wen,
    output logic [ADDR_W-1:0] cs_waddr,
    output logic [DATA_W-1:0] cs_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_in;
    logic [ADDR_W-1:0] addr_q;
    logic              start_ok;
    logic              pk_load;
    logic              pk_last;
    logic              last_addr;

    // Clamping the count is what keeps addr from ever wrapping.
    assign cnt_in    = (word_count > MAX_CNT) ? MAX_CNT : word_count;
    assign start_ok  = (state_q == ST_IDLE) && start;
    assign pk_load   = (state_q == ST_RECV) && s_valid;
    assign last_addr = ({1'b0, addr_q} == cnt_q - CNT_W'(1));

    mic1_word_packer #(
        .DATA_W (DATA_W),
        .BYTES  (BYTES_PER_WORD)
    ) u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .load  (pk_load),
        .data  (s_data),
        .word  (cs_wdata),
        .last  (pk_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        cs_wen  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_d = (cnt_in == '0) ? ST_DONE : ST_RECV;
            end
            ST_RECV: begin
                s_ready = 1'b1;
                if (s_valid && pk_last)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                cs_wen = 1'b1;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                state_d = last_addr ? ST_CHECK : ST_RECV;
`else
                state_d = last_addr ? ST_DONE : ST_RECV;
`endif
            end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                s_ready = 1'b1;
                if (s_valid)
                    state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu_hold = busy;
    assign cs_waddr = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else if (start_ok) begin
            cnt_q  <= cnt_in;
            addr_q <= '0;
        end else if (state_q == ST_WRITE && !last_addr) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

`ifdef MICROCODE_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       error_q;

    // Sum covers every received data byte in full, including bits dropped from the top lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else if (start_ok) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else if (pk_load) begin
            sum_q <= sum_q + s_data;
        end else if (state_q == ST_CHECK && s_valid) begin
            error_q <= (s_data != sum_q);
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_microcode_loader.sv
// Scoreboard bench for microcode_loader: expected writes queued as bytes are sent, checked on cs_wen.
module tb_microcode_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  word_count = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready, cs_wen, busy, cpu_hold, done, error;
    logic [8:0]  cs_waddr;
    logic [35:0] cs_wdata;

    always #5 clk = ~clk;

    microcode_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .cs_wen     (cs_wen),
        .cs_waddr   (cs_waddr),
        .cs_wdata   (cs_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic [8:0]  a;
        logic [35:0] d;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [35:0] mem [512];
    logic [35:0] wbuf [512];
    logic [3:0]  nib [512];
    logic [7:0]  csum;

    // Control store model plus scoreboard check on every write.
    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (cs_wen) begin
            wr_cnt++;
            mem[cs_waddr] = cs_wdata;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL cs_write_unexpected addr=%0d data=%h", cs_waddr, cs_wdata);
            end else begin
                e = sb.pop_front();
                if (cs_waddr !== e.a || cs_wdata !== e.d) begin
                    bad++;
                    $display("FAIL cs_write got addr=%0d data=%h want addr=%0d data=%h",
                             cs_waddr, cs_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 0;
        bit hs;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 64 && !got; t++) begin
            hs = s_ready;
            @(negedge clk);
            if (hs) got = 1;
        end
        s_valid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL byte_accept timeout data=%h", b);
        end
    endtask

    task automatic send_word(input int i, input int gapmax);
        logic [7:0] b;
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            b = (k < 4) ? wbuf[i][8*k +: 8] : {nib[i], wbuf[i][35:32]};
            csum = csum + b;
            if (k == 4) begin
                e.a = i[8:0];
                e.d = wbuf[i];
                sb.push_back(e);
            end
            send_byte(b, (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        end
    endtask

    task automatic start_pulse(input int n);
        start      = 1'b1;
        word_count = n[9:0];
        csum       = '0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL busy_rise busy=%b cpu_hold=%b want 1", busy, cpu_hold);
        end
    endtask

    task automatic finish_load(input int delta);
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        logic [7:0] cb;
        cb = csum + delta[7:0];
        send_byte(cb, 0);
`else
        @(negedge clk);
`endif
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse done=%b want 1", done);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL busy_fall busy=%b done=%b want 0 0", busy, done);
        end
        total++;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        if (error !== (delta != 0)) begin
            bad++;
            $display("FAIL error_flag got=%b want=%b", error, (delta != 0));
        end
`else
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL error_flag got=%b want 0", error);
        end
`endif
    endtask

    task automatic fill_random(input int n);
        logic [31:0] r1, r2;
        for (int i = 0; i < n; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            wbuf[i] = {r2[3:0], r1};
            nib[i]  = r2[7:4];
        end
    endtask

    task automatic test_reset();
        bit sr_seen = 0;
        int w0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({s_ready, cs_wen, busy, cpu_hold, done, error} !== 6'b0 ||
            cs_waddr !== 9'd0 || cs_wdata !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs flags=%b addr=%0d data=%h want all 0",
                     {s_ready, cs_wen, busy, cpu_hold, done, error}, cs_waddr, cs_wdata);
        end
        w0 = wr_cnt;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        for (int t = 0; t < 5; t++) begin
            if (s_ready !== 1'b0) sr_seen = 1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        total++;
        if (sr_seen || wr_cnt != w0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_handshake s_ready_seen=%b writes=%0d busy=%b want 0 0 0",
                     sr_seen, wr_cnt - w0, busy);
        end
    endtask

    task automatic test_single_word();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        wbuf[0] = 36'h9_1234_5678;
        nib[0]  = 4'hF;
        start_pulse(1);
        send_word(0, 0);
        finish_load(0);
        total++;
        if (wr_cnt - w0 != 1 || done_cnt - d0 != 1 || mem[0] !== 36'h9_1234_5678) begin
            bad++;
            $display("FAIL single_word writes=%0d dones=%0d mem0=%h want 1 1 912345678",
                     wr_cnt - w0, done_cnt - d0, mem[0]);
        end
    endtask

    task automatic test_full_store();
        int w0 = wr_cnt;
        int errs = 0;
        fill_random(512);
        start_pulse(600);
        for (int i = 0; i < 512; i++) send_word(i, 0);
        finish_load(0);
        for (int i = 0; i < 512; i++) if (mem[i] !== wbuf[i]) errs++;
        total++;
        if (wr_cnt - w0 != 512 || errs != 0) begin
            bad++;
            $display("FAIL full_store writes=%0d readback_errs=%0d want 512 0", wr_cnt - w0, errs);
        end
    endtask

    task automatic test_stalls();
        int w0;
        int errs = 0;
        fill_random(8);
        start_pulse(8);
        for (int i = 0; i < 8; i++) send_word(i, 0);
        finish_load(0);
        for (int i = 0; i < 8; i++) mem[i] = 'x;
        w0 = wr_cnt;
        start_pulse(8);
        for (int i = 0; i < 8; i++) send_word(i, 7);
        finish_load(0);
        for (int i = 0; i < 8; i++) if (mem[i] !== wbuf[i]) errs++;
        total++;
        if (wr_cnt - w0 != 8 || errs != 0) begin
            bad++;
            $display("FAIL stalls writes=%0d readback_errs=%0d want 8 0", wr_cnt - w0, errs);
        end
    endtask

    task automatic test_checksum();
        int w0;
        fill_random(2);
        w0 = wr_cnt;
        start_pulse(2);
        send_word(0, 0);
        send_word(1, 0);
        finish_load(1);
        repeat (5) @(negedge clk);
        total++;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        if (error !== 1'b1 || wr_cnt - w0 != 2) begin
            bad++;
            $display("FAIL csum_sticky error=%b writes=%0d want 1 2", error, wr_cnt - w0);
        end
`else
        if (error !== 1'b0 || wr_cnt - w0 != 2) begin
            bad++;
            $display("FAIL csum_absent error=%b writes=%0d want 0 2", error, wr_cnt - w0);
        end
`endif
        start_pulse(0);
        total++;
        if (error !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL csum_clear error=%b done=%b want 0 1", error, done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        start_pulse(0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL zero_done done=%b want 1", done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (wr_cnt != w0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_count writes=%0d dones=%0d busy=%b want 0 1 0",
                     wr_cnt - w0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_start_busy();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        fill_random(2);
        start_pulse(2);
        send_word(0, 0);
        start      = 1'b1;
        word_count = 10'd1;
        @(negedge clk);
        start = 1'b0;
        send_word(1, 0);
        finish_load(0);
        total++;
        if (wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL start_while_busy writes=%0d dones=%0d want 2 1", wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int w0;
        fill_random(3);
        w0 = wr_cnt;
        start_pulse(3);
        send_word(0, 0);
        for (int k = 0; k < 3; k++) send_byte(wbuf[1][8*k +: 8], 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || cs_wen !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle busy=%b s_ready=%b cs_wen=%b want 0 0 0", busy, s_ready, cs_wen);
        end
        repeat (10) @(negedge clk);
        total++;
        if (wr_cnt - w0 != 1 || mem[0] !== wbuf[0]) begin
            bad++;
            $display("FAIL abort_writes writes=%0d mem0=%h want 1 %h", wr_cnt - w0, mem[0], wbuf[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_zero_count();
        test_start_busy();
        test_stalls();
        test_checksum();
        test_full_store();
        test_abort();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover count=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
